// File: rtl/nv_nvdla_pdp_pkg.sv
// Shared PDP definitions: FSM state encoding, atom geometry and cube-walk helpers.
package nv_nvdla_pdp_pkg;

  localparam int PDP_ATOM_BYTES = 8;
  localparam int PDP_CNT_W      = 13;

  typedef enum logic [1:0] {
    PDP_IDLE = 2'd0,
    PDP_RUN  = 2'd1,
    PDP_DONE = 2'd2
  } pdp_state_e;

  // Position in the output cube: atom within line, line within surface, surface.
  typedef struct packed {
    logic [PDP_CNT_W-1:0] w;
    logic [PDP_CNT_W-1:0] h;
    logic [PDP_CNT_W-1:0] s;
  } pdp_pos_t;

  function automatic pdp_pos_t pdp_pos_next(input pdp_pos_t pos,
                                            input logic [PDP_CNT_W-1:0] width,
                                            input logic [PDP_CNT_W-1:0] height);
    pdp_pos_t nxt;
    nxt = pos;
    if (pos.w < width) begin
      nxt.w = pos.w + PDP_CNT_W'(1);
    end else begin
      nxt.w = '0;
      if (pos.h < height) begin
        nxt.h = pos.h + PDP_CNT_W'(1);
      end else begin
        nxt.h = '0;
        nxt.s = pos.s + PDP_CNT_W'(1);
      end
    end
    return nxt;
  endfunction

  function automatic logic pdp_pos_is_last(input pdp_pos_t pos,
                                           input logic [PDP_CNT_W-1:0] width,
                                           input logic [PDP_CNT_W-1:0] height,
                                           input logic [PDP_CNT_W-1:0] surf_last);
    return (pos.w == width) && (pos.h == height) && (pos.s == surf_last);
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_wdma_fifo.sv
// Small synchronous FIFO for PDP write atoms; head entry is read straight from storage registers.
module nv_nvdla_pdp_wdma_fifo #(
  parameter int  DATA_W = 64,
  parameter int  DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage has no reset; only pointers and count define validity, so a reset empties the FIFO.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/nv_nvdla_pdp_wdma_ingress.sv
// PDP-to-WDMA ingress: buffers pooled atoms and issues one addressed DMA write per atom.
// Optional macro NVDLA_PDP_WDMA_PERF_EN adds the dp2reg_wdma_stall_cnt output.
module nv_nvdla_pdp_wdma_ingress
  import nv_nvdla_pdp_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 reg2dp_op_en,
  input  logic [12:0]          reg2dp_cube_out_width,
  input  logic [12:0]          reg2dp_cube_out_height,
  input  logic [12:0]          reg2dp_cube_out_channel,
  input  logic [ADDR_W-1:0]    reg2dp_dst_base_addr,
  input  logic [31:0]          reg2dp_dst_line_stride,
  input  logic [31:0]          reg2dp_dst_surface_stride,
  input  logic                 pdp_dp2wdma_valid,
  input  logic [DATA_W-1:0]    pdp_dp2wdma_pd,
  output logic                 pdp_dp2wdma_ready,
  output logic                 dma_wr_req_valid,
  input  logic                 dma_wr_req_ready,
  output logic [ADDR_W-1:0]    dma_wr_req_addr,
  output logic [DATA_W-1:0]    dma_wr_req_data,
  output logic                 dma_wr_req_last,
  output logic                 dp2reg_done
`ifdef NVDLA_PDP_WDMA_PERF_EN
  ,
  output logic [31:0]          dp2reg_wdma_stall_cnt
`endif
);

  localparam int ATOM_STEP  = DATA_W / 8;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  pdp_state_e              state_q, state_d;
  logic [PDP_CNT_W-1:0]    cfg_width, cfg_height, cfg_surf_last;
  logic [31:0]             cfg_line_stride, cfg_surf_stride;
  logic [ADDR_W-1:0]       line_base, surf_base;
  pdp_pos_t                out_pos, in_pos;
  logic                    all_in;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [DATA_W-1:0]       fifo_head;
  logic                    start, push, pop, req_last;

  assign start    = (state_q == PDP_IDLE) && reg2dp_op_en;
  assign push     = pdp_dp2wdma_valid && pdp_dp2wdma_ready;
  assign pop      = dma_wr_req_valid && dma_wr_req_ready;
  assign req_last = pdp_pos_is_last(out_pos, cfg_width, cfg_height, cfg_surf_last);

  // Ready depends only on registered state, never on the downstream ready.
  assign pdp_dp2wdma_ready = (state_q == PDP_RUN) && (fifo_count < FIFO_CNT_W'(FIFO_DEPTH)) && !all_in;
  assign dma_wr_req_valid  = (state_q == PDP_RUN) && (fifo_count != '0);
  assign dma_wr_req_addr   = line_base + ADDR_W'(out_pos.w) * ADDR_W'(ATOM_STEP);
  assign dma_wr_req_data   = dma_wr_req_valid ? fifo_head : '0;
  assign dma_wr_req_last   = dma_wr_req_valid && req_last;
  assign dp2reg_done       = (state_q == PDP_DONE);

  nv_nvdla_pdp_wdma_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push            (push),
    .push_data       (pdp_dp2wdma_pd),
    .pop             (pop),
    .head_data       (fifo_head),
    .count           (fifo_count)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= PDP_IDLE;
    else                  state_q <= state_d;
  end

  // NOTE: defaulting state_d first keeps this block purely combinational (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      PDP_IDLE: if (reg2dp_op_en)    state_d = PDP_RUN;
      PDP_RUN:  if (pop && req_last) state_d = PDP_DONE;
      PDP_DONE:                      state_d = PDP_IDLE;
      default:                       state_d = PDP_IDLE;
    endcase
  end

  // Output-side position tracks the head request; input-side position tracks accepted atoms.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cfg_width       <= '0;
      cfg_height      <= '0;
      cfg_surf_last   <= '0;
      cfg_line_stride <= '0;
      cfg_surf_stride <= '0;
      line_base       <= '0;
      surf_base       <= '0;
      out_pos         <= '0;
      in_pos          <= '0;
      all_in          <= 1'b0;
    end else if (start) begin
      cfg_width       <= reg2dp_cube_out_width;
      cfg_height      <= reg2dp_cube_out_height;
      cfg_surf_last   <= PDP_CNT_W'(reg2dp_cube_out_channel >> 3);
      cfg_line_stride <= reg2dp_dst_line_stride;
      cfg_surf_stride <= reg2dp_dst_surface_stride;
      line_base       <= reg2dp_dst_base_addr;
      surf_base       <= reg2dp_dst_base_addr;
      out_pos         <= '0;
      in_pos          <= '0;
      all_in          <= 1'b0;
    end else begin
      if (push) begin
        if (pdp_pos_is_last(in_pos, cfg_width, cfg_height, cfg_surf_last)) all_in <= 1'b1;
        else in_pos <= pdp_pos_next(in_pos, cfg_width, cfg_height);
      end
      if (pop) begin
        out_pos <= pdp_pos_next(out_pos, cfg_width, cfg_height);
        if (out_pos.w >= cfg_width) begin
          if (out_pos.h < cfg_height) begin
            line_base <= line_base + ADDR_W'(cfg_line_stride);
          end else begin
            surf_base <= surf_base + ADDR_W'(cfg_surf_stride);
            line_base <= surf_base + ADDR_W'(cfg_surf_stride);
          end
        end
      end
    end
  end

`ifdef NVDLA_PDP_WDMA_PERF_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dp2reg_wdma_stall_cnt <= '0;
    end else if (start) begin
      dp2reg_wdma_stall_cnt <= '0;
    end else if (dma_wr_req_valid && !dma_wr_req_ready && (dp2reg_wdma_stall_cnt != '1)) begin
      dp2reg_wdma_stall_cnt <= dp2reg_wdma_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_ingress.sv
// Scoreboard bench for nv_nvdla_pdp_wdma_ingress: directed cubes, stall, reset and optional perf counter.
module tb_nv_nvdla_pdp_wdma_ingress;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rstn = 1'b0;
  logic        reg2dp_op_en = 1'b0;
  logic [12:0] reg2dp_cube_out_width = '0;
  logic [12:0] reg2dp_cube_out_height = '0;
  logic [12:0] reg2dp_cube_out_channel = '0;
  logic [63:0] reg2dp_dst_base_addr = '0;
  logic [31:0] reg2dp_dst_line_stride = '0;
  logic [31:0] reg2dp_dst_surface_stride = '0;
  logic        pdp_dp2wdma_valid = 1'b0;
  logic [63:0] pdp_dp2wdma_pd = '0;
  logic        pdp_dp2wdma_ready;
  logic        dma_wr_req_valid;
  logic        dma_wr_req_ready = 1'b1;
  logic [63:0] dma_wr_req_addr;
  logic [63:0] dma_wr_req_data;
  logic        dma_wr_req_last;
  logic        dp2reg_done;
`ifdef NVDLA_PDP_WDMA_PERF_EN
  logic [31:0] dp2reg_wdma_stall_cnt;
`endif

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nv_nvdla_pdp_wdma_ingress dut (
    .nvdla_core_clk            (nvdla_core_clk),
    .nvdla_core_rstn           (nvdla_core_rstn),
    .reg2dp_op_en              (reg2dp_op_en),
    .reg2dp_cube_out_width     (reg2dp_cube_out_width),
    .reg2dp_cube_out_height    (reg2dp_cube_out_height),
    .reg2dp_cube_out_channel   (reg2dp_cube_out_channel),
    .reg2dp_dst_base_addr      (reg2dp_dst_base_addr),
    .reg2dp_dst_line_stride    (reg2dp_dst_line_stride),
    .reg2dp_dst_surface_stride (reg2dp_dst_surface_stride),
    .pdp_dp2wdma_valid         (pdp_dp2wdma_valid),
    .pdp_dp2wdma_pd            (pdp_dp2wdma_pd),
    .pdp_dp2wdma_ready         (pdp_dp2wdma_ready),
    .dma_wr_req_valid          (dma_wr_req_valid),
    .dma_wr_req_ready          (dma_wr_req_ready),
    .dma_wr_req_addr           (dma_wr_req_addr),
    .dma_wr_req_data           (dma_wr_req_data),
    .dma_wr_req_last           (dma_wr_req_last),
    .dp2reg_done               (dp2reg_done)
`ifdef NVDLA_PDP_WDMA_PERF_EN
    ,
    .dp2reg_wdma_stall_cnt     (dp2reg_wdma_stall_cnt)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sb_en = 1'b1;
  int          atoms_sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] addr, input logic [63:0] data, input logic last);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.last = last;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every accepted request and checks request hold under stall.
  initial begin : monitor
    exp_t        e;
    bit          hold_pend = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [63:0] hold_data = '0;
    forever begin
      @(negedge nvdla_core_clk);
      if (!nvdla_core_rstn) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 64'(dma_wr_req_valid), 64'd1);
          check("hold_addr", dma_wr_req_addr, hold_addr);
          check("hold_data", dma_wr_req_data, hold_data);
        end
        hold_pend = dma_wr_req_valid && !dma_wr_req_ready;
        hold_addr = dma_wr_req_addr;
        hold_data = dma_wr_req_data;
        if (sb_en && dma_wr_req_valid && dma_wr_req_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_req: got addr 0x%0h expected no request", dma_wr_req_addr);
          end else begin
            e = sb.pop_front();
            check("req_addr", dma_wr_req_addr, e.addr);
            check("req_data", dma_wr_req_data, e.data);
            check("req_last", 64'(dma_wr_req_last), 64'(e.last));
          end
        end
      end
    end
  end

  task automatic set_cfg(input logic [12:0] w, input logic [12:0] h, input logic [12:0] c,
                         input logic [63:0] base, input logic [31:0] ls, input logic [31:0] ss);
    reg2dp_cube_out_width     = w;
    reg2dp_cube_out_height    = h;
    reg2dp_cube_out_channel   = c;
    reg2dp_dst_base_addr      = base;
    reg2dp_dst_line_stride    = ls;
    reg2dp_dst_surface_stride = ss;
  endtask

  // Called just after a rising edge; the DUT enters RUN on the next edge.
  task automatic start_op();
    reg2dp_op_en = 1'b1;
    @(posedge nvdla_core_clk);
    #1 reg2dp_op_en = 1'b0;
  endtask

  task automatic send_atoms(input int n, input logic [63:0] tag);
    bit acc;
    for (int i = 0; i < n; i++) begin
      pdp_dp2wdma_pd    = tag | 64'(i);
      pdp_dp2wdma_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
        @(negedge nvdla_core_clk);
        acc = pdp_dp2wdma_ready;
        @(posedge nvdla_core_clk);
        #1;
      end
      if (!acc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL atom_accept_timeout: got no ready for atom %0d expected acceptance", i);
        break;
      end
      atoms_sent++;
    end
    pdp_dp2wdma_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge nvdla_core_clk);
      if (dp2reg_done) break;
    end
    check("done_pulse", 64'(dp2reg_done), 64'd1);
    @(negedge nvdla_core_clk);
    check("done_one_cycle", 64'(dp2reg_done), 64'd0);
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 64'(pdp_dp2wdma_ready), 64'd0);
    check({tag, "_req_valid"}, 64'(dma_wr_req_valid), 64'd0);
    check({tag, "_req_addr"}, dma_wr_req_addr, 64'd0);
    check({tag, "_req_data"}, dma_wr_req_data, 64'd0);
    check({tag, "_req_last"}, 64'(dma_wr_req_last), 64'd0);
    check({tag, "_done"}, 64'(dp2reg_done), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(posedge nvdla_core_clk);
    @(negedge nvdla_core_clk);
    check_outputs_zero("reset");
    @(posedge nvdla_core_clk);
    #1 nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk);
    #1;

    // 1: two atoms on one line, last on the second.
    set_cfg(13'd1, 13'd0, 13'd7, 64'h1000, 32'h100, 32'h800);
    sb_push(64'h1000, 64'hA100_0000_0000_0000, 1'b0);
    sb_push(64'h1008, 64'hA100_0000_0000_0001, 1'b1);
    start_op();
    send_atoms(2, 64'hA100_0000_0000_0000);
    wait_done();

    // 2: three lines of one atom each.
    set_cfg(13'd0, 13'd2, 13'd0, 64'h1000, 32'h100, 32'h800);
    sb_push(64'h1000, 64'hA200_0000_0000_0000, 1'b0);
    sb_push(64'h1100, 64'hA200_0000_0000_0001, 1'b0);
    sb_push(64'h1200, 64'hA200_0000_0000_0002, 1'b1);
    start_op();
    send_atoms(3, 64'hA200_0000_0000_0000);
    wait_done();

    // 3: two surfaces of one atom.
    set_cfg(13'd0, 13'd0, 13'd15, 64'h1000, 32'h100, 32'h800);
    sb_push(64'h1000, 64'hA300_0000_0000_0000, 1'b0);
    sb_push(64'h1800, 64'hA300_0000_0000_0001, 1'b1);
    start_op();
    send_atoms(2, 64'hA300_0000_0000_0000);
    wait_done();

    // 4: downstream stalled for 10 cycles with input always valid.
    set_cfg(13'd3, 13'd0, 13'd7, 64'h1000, 32'h100, 32'h800);
    for (int i = 0; i < 4; i++)
      sb_push(64'h1000 + 64'(i * 8), 64'hA400_0000_0000_0000 | 64'(i), i == 3);
    dma_wr_req_ready = 1'b0;
    atoms_sent = 0;
    start_op();
    fork
      send_atoms(4, 64'hA400_0000_0000_0000);
      begin
        repeat (10) @(posedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        check("stall_in_ready", 64'(pdp_dp2wdma_ready), 64'd0);
        check("stall_req_valid", 64'(dma_wr_req_valid), 64'd1);
        check("stall_req_addr", dma_wr_req_addr, 64'h1000);
        check("stall_req_data", dma_wr_req_data, 64'hA400_0000_0000_0000);
        check("stall_atoms_held", 64'(atoms_sent), 64'd2);
        @(posedge nvdla_core_clk);
        #1 dma_wr_req_ready = 1'b1;
      end
    join
    wait_done();

    // 5: async reset after 3 of 8 atoms, then a clean restart.
    set_cfg(13'd7, 13'd0, 13'd7, 64'h1000, 32'h100, 32'h800);
    sb_en = 1'b0;
    start_op();
    send_atoms(3, 64'hA500_0000_0000_0000);
    #1 nvdla_core_rstn = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge nvdla_core_clk);
    check_outputs_zero("rst_edge");
    @(posedge nvdla_core_clk);
    #1 nvdla_core_rstn = 1'b1;
    sb_en = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    for (int i = 0; i < 8; i++)
      sb_push(64'h1000 + 64'(i * 8), 64'hA550_0000_0000_0000 | 64'(i), i == 7);
    start_op();
    send_atoms(8, 64'hA550_0000_0000_0000);
    wait_done();

`ifdef NVDLA_PDP_WDMA_PERF_EN
    // 6: seven stalled cycles counted, then cleared by the next op.
    set_cfg(13'd0, 13'd0, 13'd0, 64'h1000, 32'h100, 32'h800);
    sb_push(64'h1000, 64'hA600_0000_0000_0000, 1'b1);
    dma_wr_req_ready = 1'b0;
    start_op();
    fork
      send_atoms(1, 64'hA600_0000_0000_0000);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge nvdla_core_clk);
          if (dma_wr_req_valid) break;
        end
        repeat (6) @(negedge nvdla_core_clk);
        @(posedge nvdla_core_clk);
        #1 dma_wr_req_ready = 1'b1;
      end
    join
    wait_done();
    check("perf_stall_cnt", 64'(dp2reg_wdma_stall_cnt), 64'd7);
    sb_push(64'h1000, 64'hA700_0000_0000_0000, 1'b1);
    start_op();
    check("perf_stall_clear", 64'(dp2reg_wdma_stall_cnt), 64'd0);
    send_atoms(1, 64'hA700_0000_0000_0000);
    wait_done();
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
